mem_request_ctrl: RTL and testbench
===================================

Name: mem_request_ctrl

Overview:
- Per-core memory request controller that sits between the datapath and the memory/cache interface.
- Generalised successor of the single-core request handshake: parametrised address/data width, latched data-request address and store value, explicit FSM, halt sequencing and a stuck-request watchdog.
- Holds imem/dmem enables across stalls and drops them on completion, halt or timeout.

Parameters:
- WORD_W, 32, width of data address and store data.
- TIMEOUT, 255, maximum cycles a data request may remain outstanding; must be ≥ 1.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- dREN  in  1  datapath requests a data read (sampled on ihit).
- dWEN  in  1  datapath requests a data write (sampled on ihit).
- daddr  in  WORD_W  data address from the datapath.
- dstore  in  WORD_W  store data from the datapath.
- halt  in  1  datapath has executed HALT.
- imemREN  out  1  instruction read enable.
- dmemREN  out  1  data read enable.
- dmemWEN  out  1  data write enable.
- dmemaddr  out  WORD_W  latched data address.
- dmemstore  out  WORD_W  latched store data.
- halted  out  1  core has quiesced; sticky.
- timeout_err  out  1  watchdog fired; sticky.
- icount  out  CNT_W  completed instruction fetches.
- dcount  out  CNT_W  completed data accesses.

Behaviour:
- Clock and reset: one clock `clk`; reset `nRST` is asynchronous and active-low.
- Reset values:
  - imemREN=1.
  - dmemREN=0, dmemWEN=0.
  - dmemaddr=0, dmemstore=0.
  - halted=0, timeout_err=0.
  - icount=0, dcount=0.
  - FSM=IDLE, watchdog=0.
- Reset asserted mid-request aborts immediately; no completion is counted.
- FSM states: IDLE, DREQ, HALTED. All outputs are registered.
- IDLE:
  - imemREN=1.
  - ihit with dWEN=1: next cycle dmemWEN=1, dmemREN=0; latch daddr and dstore; go to DREQ.
  - ihit with dREN=1 and dWEN=0: next cycle dmemREN=1; latch daddr; go to DREQ.
  - dREN and dWEN both high: write wins; dmemREN and dmemWEN are never high together.
  - halt=1 with no data request launching this cycle: go to HALTED.
  - halt=1 together with ihit and a data request: the request launches first and the halt is honoured after it completes.
- DREQ:
  - imemREN stays 1; ihit is ignored (no new launch).
  - Watchdog increments each cycle.
  - dhit: next cycle dmemREN=dmemWEN=0, watchdog cleared. Next state is HALTED if halt is high or a halt is pending, else IDLE.
  - Watchdog reaches TIMEOUT without dhit: same as dhit, except timeout_err<=1 and dcount is not incremented.
  - dhit and watchdog expiry in the same cycle: dhit wins; no error.
  - Halt pending bit is set when halt=1 is seen in DREQ and cleared on leaving DREQ.
- HALTED:
  - imemREN=0, dmemREN=dmemWEN=0, halted=1.
  - Terminal until reset; ihit, dhit and halt are ignored.
- dmemaddr and dmemstore change only on launch and are held stable for the whole of DREQ.
- Watchdog width: ceil(log2(TIMEOUT+1)) bits; it never wraps.

Optional Feature:
- Macro: MEM_REQUEST_CTRL_STATS_EN.
- Defined:
  - icount increments on each ihit while not HALTED.
  - dcount increments on each dhit in DREQ.
  - Both counters saturate at 2^CNT_W−1 and do not wrap.
- Undefined: icount and dcount are constant 0; no counter flops are synthesised. Port list is unchanged.

Test Plan:
- Reset, then ihit with dREN=1, daddr=0x0000_0040: next cycle dmemREN=1, dmemWEN=0, dmemaddr=0x40. dhit 3 cycles later: next cycle dmemREN=0, state IDLE, imemREN=1 throughout.
- ihit with dREN=1, dWEN=1, daddr=0x80, dstore=0xDEADBEEF: dmemWEN=1, dmemREN=0, dmemstore=0xDEADBEEF. Change daddr/dstore during DREQ: outputs unchanged until dhit.
- halt=1 pulsed for one cycle during DREQ: no change until dhit. Cycle after dhit: halted=1, imemREN=0, dmem enables 0. Later ihit/dhit/halt: no change.
- TIMEOUT=4, launch read, never assert dhit: exactly 4 cycles in DREQ, then timeout_err=1, dmemREN=0, IDLE, dcount unchanged. Variant with dhit on the expiry cycle: timeout_err stays 0.
- With MEM_REQUEST_CTRL_STATS_EN, CNT_W=2: 5 ihits → icount=3 (saturated); 2 completed data accesses → dcount=2. Without the macro, both stay 0.
- Assert nRST low asynchronously mid-DREQ (between clock edges): outputs return to reset values immediately; after release, imemREN=1 and state IDLE.

Source files
------------

// File: rtl/mem_request_ctrl_if.sv
// Handshake bundle between the datapath/memory side and the per-core memory request controller.
// The controller connects through the slave modport; the driving side uses master.
interface mem_request_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              ihit;
  logic              dhit;
  logic              dREN;
  logic              dWEN;
  logic              halt;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              halted;
  logic              timeout_err;
  logic [CNT_W-1:0]  icount;
  logic [CNT_W-1:0]  dcount;

  modport master (
    output ihit, dhit, dREN, dWEN, halt, daddr, dstore,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, halted, timeout_err, icount, dcount
  );

  modport slave (
    input  ihit, dhit, dREN, dWEN, halt, daddr, dstore,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, halted, timeout_err, icount, dcount
  );
endinterface

// File: rtl/mem_request_ctrl.sv
// Per-core memory request controller: launches one data access per fetch, halts, and watchdogs stuck requests.
// Define MEM_REQUEST_CTRL_STATS_EN to build the saturating icount/dcount statistics counters.
module mem_request_ctrl #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              nRST,
  mem_request_ctrl_if.slave bus
);
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DREQ, ST_HALTED} state_t;

  state_t            r_state;
  logic [WD_W-1:0]   r_wd;
  logic              r_pend;
  logic              r_imem;
  logic              r_ren;
  logic              r_wen;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic              r_halted;
  logic              r_terr;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_wd     <= '0;
      r_pend   <= 1'b0;
      r_imem   <= 1'b1;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_store  <= '0;
      r_halted <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_imem <= 1'b1;
          if (bus.ihit && bus.dWEN) begin
            r_wen   <= 1'b1;
            r_ren   <= 1'b0;
            r_addr  <= bus.daddr;
            r_store <= bus.dstore;
            r_pend  <= bus.halt;
            r_wd    <= '0;
            r_state <= ST_DREQ;
          end else if (bus.ihit && bus.dREN) begin
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
            r_addr  <= bus.daddr;
            r_pend  <= bus.halt;
            r_wd    <= '0;
            r_state <= ST_DREQ;
          end else if (bus.halt) begin
            r_imem   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= ST_HALTED;
          end
        end
        ST_DREQ: begin
          // dhit takes priority over watchdog expiry in the same cycle
          if (bus.dhit || (r_wd == WD_LAST)) begin
            r_ren  <= 1'b0;
            r_wen  <= 1'b0;
            r_wd   <= '0;
            r_pend <= 1'b0;
            if (!bus.dhit) r_terr <= 1'b1;
            if (bus.halt || r_pend) begin
              r_imem   <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_wd <= r_wd + WD_W'(1);
            if (bus.halt) r_pend <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_imem   <= 1'b0;
          r_ren    <= 1'b0;
          r_wen    <= 1'b0;
          r_halted <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imemREN     = r_imem;
  assign bus.dmemREN     = r_ren;
  assign bus.dmemWEN     = r_wen;
  assign bus.dmemaddr    = r_addr;
  assign bus.dmemstore   = r_store;
  assign bus.halted      = r_halted;
  assign bus.timeout_err = r_terr;

`ifdef MEM_REQUEST_CTRL_STATS_EN
  logic [CNT_W-1:0] r_icount;
  logic [CNT_W-1:0] r_dcount;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_icount <= '0;
      r_dcount <= '0;
    end else begin
      if (bus.ihit && (r_state != ST_HALTED) && (r_icount != {CNT_W{1'b1}}))
        r_icount <= r_icount + CNT_W'(1);
      if (bus.dhit && (r_state == ST_DREQ) && (r_dcount != {CNT_W{1'b1}}))
        r_dcount <= r_dcount + CNT_W'(1);
    end
  end

  assign bus.icount = r_icount;
  assign bus.dcount = r_dcount;
`else
  assign bus.icount = {CNT_W{1'b0}};
  assign bus.dcount = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_mem_request_ctrl.sv
// Self-checking bench for mem_request_ctrl: vector table, directed corner sequences, random vs reference model.
module tb_mem_request_ctrl;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef MEM_REQUEST_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  mem_request_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  mem_request_ctrl #(.WORD_W(WORD_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus copies the model reads
  logic        s_ihit, s_dhit, s_dren, s_dwen, s_halt;
  logic [31:0] s_addr, s_store;

  // reference model: request bookkeeping in plain terms
  bit          m_busy, m_write, m_pend, m_halted, m_err;
  logic [31:0] m_addr, m_store;
  int          m_age, m_icnt, m_dcnt;

  typedef struct {
    logic        ihit, dhit, dren, dwen, halt;
    logic [31:0] addr, store;
    logic        imem, ren, wen;
    logic [31:0] eaddr, estore;
    logic        halted, err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_write = 0; m_pend = 0; m_halted = 0; m_err = 0;
    m_addr = '0; m_store = '0; m_age = 0; m_icnt = 0; m_dcnt = 0;
  endtask

  task automatic model_step();
    if (m_halted) return;
    if (s_ihit && m_icnt < CMAX) m_icnt++;
    if (m_busy) begin
      m_age++;
      if (s_halt) m_pend = 1;
      if (s_dhit || m_age == TIMEOUT) begin
        if (s_dhit) begin
          if (m_dcnt < CMAX) m_dcnt++;
        end else m_err = 1;
        m_busy = 0;
        m_halted = m_pend;
        m_pend = 0;
        m_age = 0;
      end
    end else if (s_ihit && (s_dren || s_dwen)) begin
      m_busy = 1;
      m_write = s_dwen;
      m_addr = s_addr;
      if (s_dwen) m_store = s_store;
      m_pend = s_halt;
      m_age = 0;
    end else if (s_halt) begin
      m_halted = 1;
    end
  endtask

  task automatic set_in(input logic ih, input logic dh, input logic dr, input logic dw,
                        input logic hl, input logic [31:0] a, input logic [31:0] st);
    s_ihit = ih; s_dhit = dh; s_dren = dr; s_dwen = dw; s_halt = hl; s_addr = a; s_store = st;
    bus.ihit = ih; bus.dhit = dh; bus.dREN = dr; bus.dWEN = dw; bus.halt = hl;
    bus.daddr = a; bus.dstore = st;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    @(negedge clk);
    nRST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imemREN"},     bus.imemREN,     !m_halted);
    chk({tag, ".dmemREN"},     bus.dmemREN,     m_busy && !m_write);
    chk({tag, ".dmemWEN"},     bus.dmemWEN,     m_busy && m_write);
    chk({tag, ".dmemaddr"},    bus.dmemaddr,    m_addr);
    chk({tag, ".dmemstore"},   bus.dmemstore,   m_store);
    chk({tag, ".halted"},      bus.halted,      m_halted);
    chk({tag, ".timeout_err"}, bus.timeout_err, m_err);
    chk({tag, ".icount"},      bus.icount,      STATS ? m_icnt : 0);
    chk({tag, ".dcount"},      bus.dcount,      STATS ? m_dcnt : 0);
  endtask

  initial begin
    nRST = 1'b1;
    idle_in();

    tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h40,32'h0,       1'b1,1'b1,1'b0,32'h40,32'h0,       1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h44,32'h11,      1'b1,1'b1,1'b0,32'h40,32'h0,       1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h48,32'h22,      1'b1,1'b1,1'b0,32'h40,32'h0,       1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h4C,32'h33,      1'b1,1'b0,1'b0,32'h40,32'h0,       1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h80,32'hDEADBEEF,1'b1,1'b0,1'b1,32'h80,32'hDEADBEEF,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h123,32'h55,     1'b1,1'b0,1'b1,32'h80,32'hDEADBEEF,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h200,32'h66,     1'b1,1'b0,1'b0,32'h80,32'hDEADBEEF,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'hC0,32'h77,      1'b1,1'b1,1'b0,32'hC0,32'hDEADBEEF,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'hC4,32'h88,      1'b1,1'b1,1'b0,32'hC0,32'hDEADBEEF,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'hC8,32'h99,      1'b1,1'b1,1'b0,32'hC0,32'hDEADBEEF,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'hCC,32'hAA,      1'b0,1'b0,1'b0,32'hC0,32'hDEADBEEF,1'b1,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b1,1'b1,32'hD0,32'hBB,      1'b0,1'b0,1'b0,32'hC0,32'hDEADBEEF,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'hD4,32'hCC,      1'b0,1'b0,1'b0,32'hC0,32'hDEADBEEF,1'b1,1'b0};

    // reset values
    do_reset();
    chk("rst.imemREN", bus.imemREN, 1'b1);
    chk("rst.dmemREN", bus.dmemREN, 1'b0);
    chk("rst.dmemWEN", bus.dmemWEN, 1'b0);
    chk("rst.dmemaddr", bus.dmemaddr, 32'h0);
    chk("rst.dmemstore", bus.dmemstore, 32'h0);
    chk("rst.halted", bus.halted, 1'b0);
    chk("rst.timeout_err", bus.timeout_err, 1'b0);
    chk("rst.icount", bus.icount, 0);
    chk("rst.dcount", bus.dcount, 0);

    // vector table
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].ihit, tbl[i].dhit, tbl[i].dren, tbl[i].dwen, tbl[i].halt, tbl[i].addr, tbl[i].store);
      step();
      chk($sformatf("tbl%0d.imemREN", i),     bus.imemREN,     tbl[i].imem);
      chk($sformatf("tbl%0d.dmemREN", i),     bus.dmemREN,     tbl[i].ren);
      chk($sformatf("tbl%0d.dmemWEN", i),     bus.dmemWEN,     tbl[i].wen);
      chk($sformatf("tbl%0d.dmemaddr", i),    bus.dmemaddr,    tbl[i].eaddr);
      chk($sformatf("tbl%0d.dmemstore", i),   bus.dmemstore,   tbl[i].estore);
      chk($sformatf("tbl%0d.halted", i),      bus.halted,      tbl[i].halted);
      chk($sformatf("tbl%0d.timeout_err", i), bus.timeout_err, tbl[i].err);
    end

    // watchdog expiry: request visible for exactly TIMEOUT cycles
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    step();
    idle_in();
    chk("to.cyc1.dmemREN", bus.dmemREN, 1'b1);
    for (int k = 2; k <= TIMEOUT; k++) begin
      step();
      chk($sformatf("to.cyc%0d.dmemREN", k), bus.dmemREN, 1'b1);
      chk($sformatf("to.cyc%0d.timeout_err", k), bus.timeout_err, 1'b0);
    end
    step();
    chk("to.exit.dmemREN", bus.dmemREN, 1'b0);
    chk("to.exit.timeout_err", bus.timeout_err, 1'b1);
    chk("to.exit.imemREN", bus.imemREN, 1'b1);
    chk("to.exit.halted", bus.halted, 1'b0);
    chk("to.exit.dcount", bus.dcount, 0);
    chk("to.exit.icount", bus.icount, STATS ? 1 : 0);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    step();
    idle_in();
    chk("to.relaunch.dmemREN", bus.dmemREN, 1'b1);
    chk("to.relaunch.sticky_err", bus.timeout_err, 1'b1);

    // dhit on the expiry cycle wins
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    step();
    idle_in();
    for (int k = 2; k <= TIMEOUT; k++) step();
    chk("toh.last.dmemREN", bus.dmemREN, 1'b1);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle_in();
    chk("toh.dmemREN", bus.dmemREN, 1'b0);
    chk("toh.timeout_err", bus.timeout_err, 1'b0);
    chk("toh.dcount", bus.dcount, STATS ? 1 : 0);

    // halt from IDLE, and halt arriving together with a launch
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step();
    idle_in();
    chk("hidle.halted", bus.halted, 1'b1);
    chk("hidle.imemREN", bus.imemREN, 1'b0);
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h240, 32'h0);
    step();
    idle_in();
    chk("hlaunch.dmemREN", bus.dmemREN, 1'b1);
    chk("hlaunch.halted", bus.halted, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle_in();
    chk("hlaunch.done.halted", bus.halted, 1'b1);
    chk("hlaunch.done.imemREN", bus.imemREN, 1'b0);
    chk("hlaunch.done.dmemREN", bus.dmemREN, 1'b0);

    // asynchronous reset in the middle of a write request
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h1234);
    step();
    idle_in();
    step();
    chk("arst.pre.dmemWEN", bus.dmemWEN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("arst.dmemWEN", bus.dmemWEN, 1'b0);
    chk("arst.dmemaddr", bus.dmemaddr, 32'h0);
    chk("arst.dmemstore", bus.dmemstore, 32'h0);
    chk("arst.imemREN", bus.imemREN, 1'b1);
    chk("arst.icount", bus.icount, 0);
    chk("arst.dcount", bus.dcount, 0);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    step();
    idle_in();
    chk("arst.after.dmemREN", bus.dmemREN, 1'b1);
    chk("arst.after.dmemaddr", bus.dmemaddr, 32'h500);

    // counter saturation
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end
    idle_in();
    chk("cnt.icount_sat", bus.icount, STATS ? CMAX : 0);
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 1'b0, k == 0, k == 1, 1'b0, 32'h600 + k, 32'h77);
      step();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end
    idle_in();
    chk("cnt.dcount", bus.dcount, STATS ? 2 : 0);
    chk("cnt.icount_hold", bus.icount, STATS ? CMAX : 0);

    // randomized traffic against the reference model
    do_reset();
    begin
      int halted_for = 0;
      for (int c = 0; c < 2500; c++) begin
        set_in($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
               $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
               $urandom_range(0, 149) == 0, $urandom, $urandom);
        step();
        check_all($sformatf("rnd%0d", c));
        if (m_halted) halted_for++;
        if (halted_for > 4) begin
          halted_for = 0;
          do_reset();
          check_all($sformatf("rnd%0d.rst", c));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
